// File: rtl/pipeline_perf_pkg.sv
// Shared types and constants for the pipeline performance counter.
// PERF_RETIRE_EN selects the four-beat readout that carries the retire count.
package pipeline_perf_pkg;

   localparam int unsigned CNT_W_DEFAULT = 32;

   typedef enum logic [1:0] {
      StIdle,
      StCount,
      StSnap,
      StHalt
   } perf_state_e;

   localparam logic [1:0] BEAT_CYC    = 2'd0;
   localparam logic [1:0] BEAT_STALL  = 2'd1;
   localparam logic [1:0] BEAT_FLUSH  = 2'd2;
   localparam logic [1:0] BEAT_RETIRE = 2'd3;

`ifdef PERF_RETIRE_EN
   localparam logic [1:0] BEAT_LAST = BEAT_RETIRE;
`else
   localparam logic [1:0] BEAT_LAST = BEAT_FLUSH;
`endif

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter: increments on en_i & inc_i, sticks at all-ones, clr_i wins.
module perf_sat_counter #(
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             inc_i,
   output logic [Width-1:0] cnt_o
);

   logic [Width-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && inc_i && (cnt_q != {Width{1'b1}})) begin
         cnt_d = cnt_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_perf_counter.sv
// Pipeline event counters with snapshot shadows and a valid/ready beat readout.
// Define PERF_RETIRE_EN to add the retire counter and its readout beat.
module pipeline_perf_counter
   import pipeline_perf_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stall_i,
   input  logic             branch_i,
   input  logic             flush_i,
   input  logic             retire_i,
   input  logic             clear_i,
   input  logic             snap_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic [31:0]      rd_data_o,
   output logic [1:0]       rd_sel_o,
   output logic             rd_last_o,
   output logic             done_o
);

   perf_state_e      state_q, state_d;
   logic [1:0]       beat_q, beat_d;
   logic             lim_snap_q, lim_snap_d;
   logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt;
   logic [CNT_W-1:0] cyc_sh_q, stall_sh_q, flush_sh_q;
   logic             limit_hit, take_snap, cnt_en, stall_ev;

   // Reaching the limit freezes counting; a limit snapshot keeps it frozen through readout.
   assign limit_hit = (limit_i != '0) && (cyc_cnt == limit_i);
   assign take_snap = (state_q == StCount) && (snap_i || limit_hit) && !clear_i;
   assign cnt_en    = start_i && !limit_hit &&
                      ((state_q == StCount) || ((state_q == StSnap) && !lim_snap_q));
   assign stall_ev  = stall_i & ~branch_i;

   perf_sat_counter #(
      .Width(CNT_W)
   ) u_cyc_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .en_i  (cnt_en),
      .inc_i (1'b1),
      .cnt_o (cyc_cnt)
   );

   perf_sat_counter #(
      .Width(CNT_W)
   ) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .en_i  (cnt_en),
      .inc_i (stall_ev),
      .cnt_o (stall_cnt)
   );

   perf_sat_counter #(
      .Width(CNT_W)
   ) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .en_i  (cnt_en),
      .inc_i (flush_i),
      .cnt_o (flush_cnt)
   );

`ifdef PERF_RETIRE_EN
   logic [CNT_W-1:0] retire_cnt, retire_sh_q;

   perf_sat_counter #(
      .Width(CNT_W)
   ) u_retire_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .en_i  (cnt_en),
      .inc_i (retire_i),
      .cnt_o (retire_cnt)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         retire_sh_q <= '0;
      end else if (clear_i) begin
         retire_sh_q <= '0;
      end else if (take_snap) begin
         retire_sh_q <= retire_cnt;
      end
   end
`else
   logic unused_retire;
   assign unused_retire = retire_i;
`endif

   // Shadows capture pre-edge counts, so events sampled on the snapshot edge are excluded.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cyc_sh_q   <= '0;
         stall_sh_q <= '0;
         flush_sh_q <= '0;
      end else if (clear_i) begin
         cyc_sh_q   <= '0;
         stall_sh_q <= '0;
         flush_sh_q <= '0;
      end else if (take_snap) begin
         cyc_sh_q   <= cyc_cnt;
         stall_sh_q <= stall_cnt;
         flush_sh_q <= flush_cnt;
      end
   end

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      lim_snap_d = lim_snap_q;
      if (clear_i) begin
         state_d    = StIdle;
         beat_d     = BEAT_CYC;
         lim_snap_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_d = StCount;
               end
            end
            StCount: begin
               if (take_snap) begin
                  state_d    = StSnap;
                  beat_d     = BEAT_CYC;
                  lim_snap_d = limit_hit;
               end
            end
            StSnap: begin
               if (rd_ready_i) begin
                  if (beat_q == BEAT_LAST) begin
                     state_d    = lim_snap_q ? StHalt : StCount;
                     beat_d     = BEAT_CYC;
                     lim_snap_d = 1'b0;
                  end else begin
                     beat_d = beat_q + 2'd1;
                  end
               end
            end
            StHalt: begin
               state_d = StHalt;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= StIdle;
         beat_q     <= BEAT_CYC;
         lim_snap_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         lim_snap_q <= lim_snap_d;
      end
   end

   always_comb begin
      rd_data_o = '0;
      unique case (beat_q)
         BEAT_CYC:    rd_data_o[CNT_W-1:0] = cyc_sh_q;
         BEAT_STALL:  rd_data_o[CNT_W-1:0] = stall_sh_q;
         BEAT_FLUSH:  rd_data_o[CNT_W-1:0] = flush_sh_q;
`ifdef PERF_RETIRE_EN
         BEAT_RETIRE: rd_data_o[CNT_W-1:0] = retire_sh_q;
`endif
         default:     rd_data_o = '0;
      endcase
   end

   assign rd_valid_o = (state_q == StSnap);
   assign rd_sel_o   = beat_q;
   assign rd_last_o  = rd_valid_o && (beat_q == BEAT_LAST);
   assign done_o     = (state_q == StHalt);

endmodule

// File: tb/tb_pipeline_perf_counter.sv
// Scoreboard bench: a behavioural counter model pushes expected beats, monitors check the stream.
// A second 16-bit instance runs long enough to exercise counter saturation.
module tb_pipeline_perf_counter;
   import pipeline_perf_pkg::*;

   localparam int unsigned W = 32;
`ifdef PERF_RETIRE_EN
   localparam int NBEATS = 4;
`else
   localparam int NBEATS = 3;
`endif
   localparam longint MAXV   = (longint'(1) << W) - 1;
   localparam longint MAXV16 = 65535;

   typedef struct {
      longint sel;
      longint data;
      longint last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start, stall, branch, flush, retire, clear, snap, ready;
   logic [W-1:0] limit;
   logic rd_valid, rd_last, done;
   logic [31:0] rd_data;
   logic [1:0] rd_sel;

   logic start16, snap16;
   logic rd_valid16, rd_last16, done16;
   logic [31:0] rd_data16;
   logic [1:0] rd_sel16;
   bit tb16_fin = 1'b0;

   pipeline_perf_counter #(.CNT_W(W)) dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .branch_i(branch),
      .flush_i(flush), .retire_i(retire), .clear_i(clear), .snap_i(snap), .limit_i(limit),
      .rd_valid_o(rd_valid), .rd_ready_i(ready), .rd_data_o(rd_data), .rd_sel_o(rd_sel),
      .rd_last_o(rd_last), .done_o(done)
   );

   pipeline_perf_counter #(.CNT_W(16)) dut16 (
      .clk_i(clk), .rst_i(rst_n), .start_i(start16), .stall_i(1'b1), .branch_i(1'b0),
      .flush_i(1'b1), .retire_i(1'b1), .clear_i(1'b0), .snap_i(snap16), .limit_i(16'd0),
      .rd_valid_o(rd_valid16), .rd_ready_i(1'b1), .rd_data_o(rd_data16), .rd_sel_o(rd_sel16),
      .rd_last_o(rd_last16), .done_o(done16)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
      end
   endtask

   // Model: counts, whether counting has started, remaining readout beats, halt.
   longint m_cnt[4];
   bit     m_started, m_halted, m_lim;
   int     m_left;
   beat_t  exp_q[$];
   beat_t  exp16_q[$];

   function automatic longint sat(input longint v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   task automatic model_edge();
      bit lim_hit, counting;
      if (clear) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_started = 0; m_halted = 0; m_lim = 0; m_left = 0;
         exp_q.delete();
         return;
      end
      if (!m_started) begin
         if (start) m_started = 1;
         return;
      end
      if (m_halted) return;
      lim_hit  = (limit != 0) && (m_cnt[0] == longint'(limit));
      counting = start && !lim_hit && !((m_left > 0) && m_lim);
      if (m_left == 0) begin
         if (lim_hit || snap) begin
            for (int b = 0; b < NBEATS; b++) begin
               exp_q.push_back('{sel: b, data: m_cnt[b], last: (b == NBEATS - 1)});
            end
            m_left = NBEATS;
            m_lim  = lim_hit;
         end
      end else if (ready) begin
         m_left--;
         if (m_left == 0) begin
            if (m_lim) m_halted = 1;
            m_lim = 0;
         end
      end
      if (counting) begin
         m_cnt[0] = sat(m_cnt[0] + 1);
         m_cnt[1] = sat(m_cnt[1] + ((stall && !branch) ? 1 : 0));
         m_cnt[2] = sat(m_cnt[2] + (flush ? 1 : 0));
         m_cnt[3] = sat(m_cnt[3] + (retire ? 1 : 0));
      end
   endtask

   always @(posedge clk) begin
      if (rst_n) model_edge();
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("rd_valid", rd_valid, (m_left > 0));
         check("done", done, m_halted);
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", exp_q.size(), 1);
            end else begin
               check("rd_sel", rd_sel, exp_q[0].sel);
               check("rd_data", rd_data, exp_q[0].data);
               check("rd_last", rd_last, exp_q[0].last);
               if (ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && rd_valid16) begin
         if (exp16_q.size() == 0) begin
            check("unexpected_beat16", exp16_q.size(), 1);
         end else begin
            check("rd_sel16", rd_sel16, exp16_q[0].sel);
            check("rd_data16_sat", rd_data16, exp16_q[0].data);
            check("rd_last16", rd_last16, exp16_q[0].last);
            void'(exp16_q.pop_front());
         end
      end
   end

   task automatic step(input logic st, input logic sl, input logic br, input logic fl,
                       input logic rt, input logic sn, input logic cl, input logic rdy);
      start = st; stall = sl; branch = br; flush = fl; retire = rt;
      snap = sn; clear = cl; ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_step(input logic st, input logic sn, input logic rdy);
      step(st, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), sn, 1'b0, rdy);
   endtask

   // Saturation: 16-bit counters run well past 65535 events before one snapshot.
   initial begin
      start16 = 1'b0;
      snap16  = 1'b0;
      wait (rst_n === 1'b1);
      @(posedge clk);
      #1 start16 = 1'b1;
      repeat (65540) @(posedge clk);
      #1 snap16 = 1'b1;
      @(posedge clk);
      for (int b = 0; b < NBEATS; b++) begin
         exp16_q.push_back('{sel: b, data: MAXV16, last: (b == NBEATS - 1)});
      end
      #1 snap16 = 1'b0;
      for (int i = 0; i < 20 && exp16_q.size() > 0; i++) @(posedge clk);
      tb16_fin = 1'b1;
   end

   initial begin
      rst_n = 1'b0;
      start = 0; stall = 0; branch = 0; flush = 0; retire = 0;
      clear = 0; snap = 0; ready = 0; limit = '0;
      #3;
      check("reset_rd_valid", rd_valid, 0);
      check("reset_rd_data", rd_data, 0);
      check("reset_rd_sel", rd_sel, 0);
      check("reset_rd_last", rd_last, 0);
      check("reset_done", done, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // start low: nothing starts, any snap request is ignored
      repeat (5) step(0, 1, 0, 1, 1, 1, 0, 1);

      // stall/branch masking: enter counting, then 10 counted cycles, then snapshot
      step(1, 0, 0, 0, 0, 0, 0, 1);
      for (int c = 0; c < 10; c++) begin
         step(1, (c == 1 || c == 4 || c == 7), (c == 4), (c == 6), 1'($urandom), 0, 0, 1);
      end
      step(1, 0, 0, 0, 0, 1, 0, 0);
      // backpressure on beat 0, then drain
      repeat (5) rnd_step(1, 0, 0);
      repeat (6) rnd_step(1, 0, 1);

      // randomized traffic with sporadic snapshots, pauses and backpressure
      repeat (300) rnd_step(($urandom % 8) != 0, ($urandom % 16) == 0, ($urandom % 4) != 0);

      // clear during beat 1, then a fresh snapshot reads all zeros
      step(0, 0, 0, 0, 0, 0, 1, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      repeat (5) rnd_step(1, 0, 1);
      step(1, 0, 0, 0, 0, 1, 0, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1, 0, 1);
      repeat (6) step(1, 0, 0, 0, 0, 0, 0, 1);

      // cycle limit: auto snapshot at 30, then halt with counters frozen
      step(0, 0, 0, 0, 0, 0, 1, 1);
      limit = W'(30);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      repeat (45) rnd_step(1, 0, ($urandom % 3) != 0);
      repeat (10) rnd_step(1, 1'($urandom), 1);
      check("limit_halted", done, 1);
      step(0, 0, 0, 0, 0, 0, 1, 1);
      limit = '0;
      check("clear_done", done, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);

      for (int i = 0; i < 70000 && !tb16_fin; i++) @(posedge clk);
      check("sat_run_finished", tb16_fin, 1);
      check("sat_beats_left", exp16_q.size(), 0);
      check("beats_left", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
